fpnew_opgroup_ordered_arbiter: RTL
==================================

// Module: fpnew_opgroup_ordered_arbiter
// PURPOSE
//  Parametrised output collector for an operation-group block. It merges results from NumSlices
//  format slices onto one valid/ready output. Mode InOrder=1 retires results strictly in issue
//  order, using an order queue of slice indices. Mode InOrder=0 grants round-robin with grant lock.
//  Tracks in-flight count and exports busy. Sits between the slices and the opgroup output port.
// PARAMETERS
//  NumSlices  5    number of slices (>=2)
//  DataWidth  38   payload bits per slice (result+status+ext_bit+tag)
//  Depth      8    order-queue depth = max in-flight ops (>=2, power of 2)
//  InOrder    1    1: issue-order retirement; 0: round-robin
//  IdxW       $clog2(NumSlices), CntW $clog2(Depth+1) (derived, do not override)
// PORTS
//  clk_i           in   1                    clock, rising edge
//  rst_i           in   1                    synchronous reset, active high
//  flush_i         in   1                    synchronous flush (same effect as reset)
//  issue_valid_i   in   1                    op dispatched to a slice this cycle
//  issue_sel_i     in   IdxW                 index of the slice receiving the op
//  issue_ready_o   out  1                    order queue can accept an entry
//  slice_valid_i   in   NumSlices            per-slice result valid
//  slice_data_i    in   NumSlices*DataWidth  per-slice payload; slice k at [k*DataWidth +: DataWidth]
//  slice_ready_o   out  NumSlices            per-slice result ready (one-hot or zero)
//  out_valid_o     out  1                    merged result valid
//  out_ready_i     in   1                    downstream ready
//  out_data_o      out  DataWidth            merged payload
//  out_sel_o       out  IdxW                 slice index of the current output
//  inflight_o      out  CntW                 ops issued but not yet retired
//  busy_o          out  1                    inflight_o != 0
//  error_o         out  1                    registered pulse: illegal issue_sel_i was seen
// BEHAVIOUR
//  Reset and flush:
//  - rst_i or flush_i high at a clock edge: queue pointers, count, RR pointer, lock and error_o
//    all clear to 0.
//  - While rst_i|flush_i is high, issue_ready_o=0, slice_ready_o=0 and out_valid_o=0
//    (combinational gating).
//  - After reset: issue_ready_o=1, out_valid_o=0, out_sel_o=0, inflight_o=0, busy_o=0, error_o=0.
//  Issue:
//  - Push occurs on issue_valid_i & issue_ready_o.
//  - issue_ready_o = (count != Depth). When full, no push occurs, even if a pop happens
//    in the same cycle.
//  - If issue_sel_i >= NumSlices, the handshake still completes but nothing is pushed.
//    error_o goes high on the next cycle, for one cycle.
//  - Same-cycle push and pop when not full: count unchanged, both pointers advance.
//    Pointers wrap modulo Depth.
//  InOrder=1:
//  - head = queue[rd_ptr].
//  - out_valid_o = !empty & slice_valid_i[head].
//  - out_data_o and out_sel_o follow head.
//  - slice_ready_o[head] = !empty & out_ready_i; all other bits 0. A result from a non-head
//    slice is held by that slice.
//  - Pop on out_valid_o & out_ready_i.
//  - Empty queue: out_valid_o=0 and slice_ready_o=0, even if a slice is valid.
//  InOrder=0:
//  - Candidates: slice_valid_i, qualified by count != 0.
//  - Grant the first valid index at or after rr_ptr, with wrap.
//  - On a handshake, rr_ptr <= grant+1 (mod NumSlices) and count decrements.
//  - Lock: if out_valid_o=1 and out_ready_i=0, the grant index is registered and held until the
//    handshake. out_data_o and out_sel_o stay stable meanwhile.
//  - The queue contents are unused; only the count is tracked.
//  Latency and ordering:
//  - Zero-cycle combinational path from slice_valid_i/data to out_*, and from out_ready_i to
//    slice_ready_o. No bubbles: back-to-back retirement runs at 1 per cycle.
//  - inflight_o and busy_o are registered. They update on the edge after a push or pop.
// TESTING
//  1 Reset: hold rst_i 2 cycles, slices valid -> out_valid_o=0, issue_ready_o=0; after release
//    issue_ready_o=1, inflight_o=0.
//  2 InOrder=1: issue sel 2,0,1 then all slices valid at once -> output sel order 2,0,1 in
//    3 consecutive cycles; inflight_o 3->0.
//  3 Full: Depth=8, issue 8 ops with no retire -> issue_ready_o=0. Pop plus issue_valid_i in the
//    same cycle -> no push, inflight_o=7.
//  4 InOrder=0: slices 1 and 3 valid, out_ready_i=0 for 3 cycles, then slice 0 becomes valid
//    -> out_sel_o stays 1 until the handshake, then grants 3, then 0.
//  5 Flush with 5 in flight, out_valid_o high -> next cycle inflight_o=0, busy_o=0,
//    out_valid_o=0.
//  6 issue_sel_i=7 with NumSlices=5 -> handshake completes, inflight_o unchanged, error_o=1
//    for exactly one cycle.

Source files
------------

// File: rtl/fpnew_opgroup_ordered_arbiter.sv
// Merges NumSlices slice results onto one valid/ready port, either in issue order (order queue)
// or round-robin with a grant lock; combinational data path, registered in-flight tracking.
module fpnew_opgroup_ordered_arbiter #(
  parameter int unsigned NumSlices = 5,
  parameter int unsigned DataWidth = 38,
  parameter int unsigned Depth     = 8,
  parameter bit          InOrder   = 1'b1,
  parameter int unsigned IdxW      = $clog2(NumSlices),
  parameter int unsigned CntW      = $clog2(Depth + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic                           issue_valid_i,
  input  logic [IdxW-1:0]                issue_sel_i,
  output logic                           issue_ready_o,
  input  logic [NumSlices-1:0]           slice_valid_i,
  input  logic [NumSlices*DataWidth-1:0] slice_data_i,
  output logic [NumSlices-1:0]           slice_ready_o,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [DataWidth-1:0]           out_data_o,
  output logic [IdxW-1:0]                out_sel_o,
  output logic [CntW-1:0]                inflight_o,
  output logic                           busy_o,
  output logic                           error_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [IdxW-1:0] queue_q [Depth];
  logic [IdxW-1:0] queue_d [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic            lock_q, lock_d;
  logic            err_q, err_d;

  logic            clr;
  logic            empty;
  logic            full;
  logic            issue_hs;
  logic            sel_legal;
  logic            push;
  logic            pop;
  logic [IdxW-1:0] head;
  logic [IdxW-1:0] rr_grant;
  logic            rr_found;
  logic [IdxW-1:0] sel;
  logic            sel_valid;
  logic [DataWidth-1:0] sel_data;

  assign clr       = rst_i | flush_i;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CntW'(Depth));
  assign head      = queue_q[rd_ptr_q];
  assign sel_legal = (32'(issue_sel_i) < NumSlices);

  assign issue_ready_o = !clr && !full;
  assign issue_hs      = issue_valid_i && issue_ready_o;
  assign push          = issue_hs && sel_legal;

  // Round-robin search from rr_ptr; a locked grant overrides it until its handshake.
  always_comb begin
    rr_found = 1'b0;
    rr_grant = rr_ptr_q;
    for (int i = 0; i < int'(NumSlices); i++) begin
      int idx;
      idx = (int'(rr_ptr_q) + i) % int'(NumSlices);
      if (!rr_found && slice_valid_i[idx]) begin
        rr_found = 1'b1;
        rr_grant = IdxW'(idx);
      end
    end
    if (lock_q) begin
      rr_grant = lock_idx_q;
    end
  end

  assign sel = InOrder ? head : rr_grant;

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < int'(NumSlices); k++) begin
      if (sel == IdxW'(k)) begin
        sel_valid = slice_valid_i[k];
        sel_data  = slice_data_i[k*DataWidth +: DataWidth];
      end
    end
  end

  // The empty check doubles as the count != 0 qualification in round-robin mode.
  assign out_valid_o = !clr && !empty && sel_valid;
  assign out_data_o  = sel_data;
  assign out_sel_o   = (InOrder && empty) ? '0 : sel;
  assign pop         = out_valid_o && out_ready_i;

  always_comb begin
    slice_ready_o = '0;
    for (int k = 0; k < int'(NumSlices); k++) begin
      if (sel == IdxW'(k)) begin
        slice_ready_o[k] = InOrder ? (!clr && !empty && out_ready_i) : pop;
      end
    end
  end

  always_comb begin
    queue_d = queue_q;
    if (push) begin
      queue_d[wr_ptr_q] = issue_sel_i;
    end
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + CntW'(push) - CntW'(pop);

    rr_ptr_d = rr_ptr_q;
    if (pop) begin
      rr_ptr_d = IdxW'((int'(sel) + 1) % int'(NumSlices));
    end

    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (out_valid_o && !out_ready_i) begin
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end else if (pop) begin
      lock_d = 1'b0;
    end

    err_d = issue_hs && !sel_legal;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
    end
  end

  // Queue storage needs no reset: entries are only read behind valid pointers.
  always_ff @(posedge clk_i) begin
    queue_q <= queue_d;
  end

  assign inflight_o = count_q;
  assign busy_o     = (count_q != '0);
  assign error_o    = err_q;

endmodule
